// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the fifo write-port arbiter family.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  // Index/counter width that never collapses to zero bits for N=1.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority encoder: returns the first set request bit
// at or above start, wrapping modulo N.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] pos;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = IDX_W'((int'(start) + k) % N);
      if (req[pos]) begin
        found = 1'b1;
        index = pos;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between N_REQ valid/ready/last
// producers; a grant lasts until last or MAX_BURST beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 16,
  localparam int IDX_W      = clog2_min1(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_data_in,
  output logic                        grant_valid,
  output logic [IDX_W-1:0]            grant_idx
);

  localparam int               CNT_W     = clog2_min1(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

  arb_state_e             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]       beat_cnt;
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic                   accept;
  logic                   burst_done;
  logic [DATA_WIDTH-1:0]  slot_data [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    assign slot_data[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_priority_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .start (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  // Handshake is combinational so a full fifo blocks the beat in the same cycle.
  always_comb begin
    req_ready  = '0;
    accept     = 1'b0;
    burst_done = 1'b0;
    if (state == ARB_GRANT && !fifo_full) begin
      req_ready[grant_idx] = 1'b1;
      accept               = req_valid[grant_idx];
      burst_done           = req_valid[grant_idx] &&
                             (req_last[grant_idx] || beat_cnt == LAST_BEAT);
    end
  end

  assign fifo_wr_en   = accept;
  assign fifo_data_in = slot_data[grant_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      beat_cnt    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            beat_cnt    <= '0;
            state       <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (burst_done) begin
            state       <= ARB_IDLE;
            grant_valid <= 1'b0;
            rr_ptr      <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
            beat_cnt    <= '0;
          end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: cycle table, directed multi-cycle sequences and
// randomized traffic checked against a beat-level reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic          fifo_full, fifo_wr_en, grant_valid;
  logic [DW-1:0] fifo_data_in;
  logic [1:0]    grant_idx;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [8:0] q    [N][$];   // {last, data} presented by each producer
  logic [8:0] pend [N][$];   // beats not yet released to the producer
  bit         full_q[$];
  bit         rand_full = 1'b0;
  bit         gen_on    = 1'b0;
  int         gen_beats = 0;
  int         wlog[$];       // idx*256 + data of every fifo write

  // Reference model: who owns the port, where the scan starts, beats written.
  int m_owner = -1;
  int m_rr    = 0;
  int m_cnt   = 0;

  typedef struct {
    bit         rst;
    logic [3:0] valid;
    logic [3:0] last;
    logic [7:0] d0;
    logic [7:0] d1;
    bit         full;
    logic [3:0] exp_ready;
    bit         exp_wr;
    bit         exp_gv;
    int         exp_gi;
    logic [7:0] exp_data;
    int         exp_rr;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit busy();
    bit b;
    b = (full_q.size() > 0);
    for (int i = 0; i < N; i++) if (q[i].size() > 0 || pend[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_rr    = 0;
    m_cnt   = 0;
  endfunction

  function automatic void push_burst(input int r, input int base, input int len, input bit with_last);
    for (int b = 0; b < len; b++) q[r].push_back({with_last && (b == len - 1), 8'(base + b)});
  endfunction

  task automatic drive_inputs();
    if (gen_on) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i].size() == 0 && q[i].size() == 0 && $urandom_range(0, 7) == 0) begin
          int len;
          len = $urandom_range(1, 7);
          for (int b = 0; b < len; b++) pend[i].push_back({b == len - 1, 8'($urandom_range(0, 255))});
          gen_beats += len;
        end
      end
    end
    for (int i = 0; i < N; i++)
      if (pend[i].size() > 0 && $urandom_range(0, 2) != 0) q[i].push_back(pend[i].pop_front());
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_last[i]          = q[i][0][8];
        req_data[i*DW +: DW] = q[i][0][7:0];
      end else begin
        req_valid[i]         = 1'b0;
        req_last[i]          = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
    if (full_q.size() > 0) fifo_full = full_q.pop_front();
    else                   fifo_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  task automatic sample_check();
    logic [N-1:0] exp_ready;
    bit           exp_wr;
    exp_ready = '0;
    exp_wr    = 1'b0;
    if (m_owner >= 0 && !fifo_full) begin
      exp_ready[m_owner] = 1'b1;
      exp_wr             = req_valid[m_owner];
    end
    chk("ready", int'(req_ready), int'(exp_ready));
    chk("wr_en", int'(fifo_wr_en), int'(exp_wr));
    chk("grant_valid", int'(grant_valid), int'(m_owner >= 0));
    if (m_owner >= 0) chk("grant_idx", int'(grant_idx), m_owner);
    if (exp_wr) chk("wr_data", int'(fifo_data_in), int'(q[m_owner][0][7:0]));
    if (fifo_wr_en) wlog.push_back(int'(grant_idx) * 256 + int'(fifo_data_in));
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i] && q[i].size() > 0) void'(q[i].pop_front());
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (req_valid[j]) begin
          m_owner = j;
          m_cnt   = 0;
          break;
        end
      end
    end else if (exp_wr) begin
      m_cnt++;
      if (req_last[m_owner] || m_cnt == MB) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_inputs();
    @(negedge clk);
    sample_check();
  endtask

  task automatic drain(input string name, input int max_cycles);
    int c;
    c = 0;
    while (busy() && c < max_cycles) begin
      step();
      c++;
    end
    chk({name, "_drained"}, int'(busy()), 0);
  endtask

  task automatic check_log(input string name, input int exp[$]);
    chk({name, "_count"}, wlog.size(), exp.size());
    for (int k = 0; k < exp.size(); k++)
      if (k < wlog.size()) chk($sformatf("%s_%0d", name, k), wlog[k], exp[k]);
    wlog.delete();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      pend[i].delete();
    end
    full_q.delete();
    wlog.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e[$];

    tbl[0]  = '{0, 4'b0001, 4'b0000, 8'hA1, 8'h00, 0, 4'b0000, 0, 0, 0, 8'h00, 0};
    tbl[1]  = '{0, 4'b0001, 4'b0000, 8'hA1, 8'h00, 0, 4'b0001, 1, 1, 0, 8'hA1, 0};
    tbl[2]  = '{0, 4'b0001, 4'b0000, 8'hA2, 8'h00, 0, 4'b0001, 1, 1, 0, 8'hA2, 0};
    tbl[3]  = '{0, 4'b0001, 4'b0001, 8'hA3, 8'h00, 0, 4'b0001, 1, 1, 0, 8'hA3, 0};
    tbl[4]  = '{0, 4'b0000, 4'b0000, 8'h00, 8'h00, 0, 4'b0000, 0, 0, 0, 8'h00, 1};
    tbl[5]  = '{1, 4'b0000, 4'b0000, 8'h00, 8'h00, 0, 4'b0000, 0, 0, 0, 8'h00, 0};
    tbl[6]  = '{0, 4'b0011, 4'b0000, 8'hB1, 8'hC1, 0, 4'b0000, 0, 0, 0, 8'h00, 0};
    tbl[7]  = '{0, 4'b0011, 4'b0000, 8'hB1, 8'hC1, 0, 4'b0001, 1, 1, 0, 8'hB1, 0};
    tbl[8]  = '{0, 4'b0011, 4'b0001, 8'hB2, 8'hC1, 0, 4'b0001, 1, 1, 0, 8'hB2, 0};
    tbl[9]  = '{0, 4'b0010, 4'b0000, 8'h00, 8'hC1, 0, 4'b0000, 0, 0, 0, 8'h00, 1};
    tbl[10] = '{0, 4'b0010, 4'b0000, 8'h00, 8'hC1, 0, 4'b0010, 1, 1, 1, 8'hC1, 1};
    tbl[11] = '{0, 4'b0010, 4'b0010, 8'h00, 8'hC2, 0, 4'b0010, 1, 1, 1, 8'hC2, 1};
    tbl[12] = '{0, 4'b0000, 4'b0000, 8'h00, 8'h00, 0, 4'b0000, 0, 0, 0, 8'h00, 2};

    // Reset state
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    #1;
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_wr_en", int'(fifo_wr_en), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gv", int'(grant_valid), 0);
    chk("rst_gi", int'(grant_idx), 0);
    chk("rst_rr", int'(dut.rr_ptr), 0);
    rst = 1'b0;

    // Cycle table: single burst, reset, two simultaneous requesters
    for (int r = 0; r < 13; r++) begin
      @(posedge clk);
      #1;
      rst       = tbl[r].rst;
      req_valid = tbl[r].valid;
      req_last  = tbl[r].last;
      req_data  = {16'h0000, tbl[r].d1, tbl[r].d0};
      fifo_full = tbl[r].full;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", r), int'(req_ready), int'(tbl[r].exp_ready));
      chk($sformatf("tbl%0d_wr_en", r), int'(fifo_wr_en), int'(tbl[r].exp_wr));
      chk($sformatf("tbl%0d_gv", r), int'(grant_valid), int'(tbl[r].exp_gv));
      if (tbl[r].exp_gv) chk($sformatf("tbl%0d_gi", r), int'(grant_idx), tbl[r].exp_gi);
      if (tbl[r].exp_wr) chk($sformatf("tbl%0d_data", r), int'(fifo_data_in), int'(tbl[r].exp_data));
      chk($sformatf("tbl%0d_rr", r), int'(dut.rr_ptr), tbl[r].exp_rr);
    end

    // Burst limit: 6 beats without last from req 0 while req 2 waits
    do_reset();
    push_burst(0, 'h10, 6, 1'b0);
    push_burst(2, 'h20, 1, 1'b1);
    drain("limit", 40);
    e = '{'h010, 'h011, 'h012, 'h013, 'h220, 'h014, 'h015};
    check_log("limit", e);
    step();
    step();
    chk("limit_hold_gv", int'(grant_valid), 1);
    chk("limit_hold_cnt", int'(dut.beat_cnt), 2);

    // Backpressure: full for 3 cycles after beat 2 of a 5-beat burst
    do_reset();
    push_burst(1, 'h30, 5, 1'b1);
    full_q = '{0, 0, 0, 1, 1, 1};
    for (int c = 0; c < 30 && busy(); c++) begin
      step();
      if (fifo_full) chk("bp_cnt_hold", int'(dut.beat_cnt), 2);
    end
    chk("bp_drained", int'(busy()), 0);
    e = '{'h130, 'h131, 'h132, 'h133, 'h134};
    check_log("bp", e);

    // Wrap-around: rr_ptr=3 with requesters 3 and 0 valid
    do_reset();
    push_burst(2, 'h40, 1, 1'b1);
    drain("wrap_pre", 10);
    step();
    chk("wrap_rr3", int'(dut.rr_ptr), 3);
    wlog.delete();
    push_burst(3, 'h50, 1, 1'b1);
    push_burst(0, 'h60, 1, 1'b1);
    drain("wrap", 20);
    step();
    e = '{'h350, 'h060};
    check_log("wrap", e);
    chk("wrap_rr_end", int'(dut.rr_ptr), 1);

    // Reset between clock edges during beat 2 of a grant
    do_reset();
    push_burst(1, 'h70, 3, 1'b1);
    step();
    step();
    @(posedge clk);
    #1;
    drive_inputs();
    #1;
    chk("mid_ready_pre", int'(req_ready), 2);
    rst = 1'b1;
    #1;
    chk("mid_ready", int'(req_ready), 0);
    chk("mid_wr_en", int'(fifo_wr_en), 0);
    chk("mid_gv", int'(grant_valid), 0);
    model_reset();
    wlog.delete();
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rr", int'(dut.rr_ptr), 0);
    push_burst(3, 'h80, 1, 1'b1);
    drain("mid", 20);
    e = '{'h171, 'h172, 'h380};
    check_log("mid", e);

    // Randomized traffic against the model
    do_reset();
    gen_beats = 0;
    rand_full = 1'b1;
    gen_on    = 1'b1;
    repeat (1500) step();
    gen_on = 1'b0;
    drain("rand", 600);
    chk("rand_beats", wlog.size(), gen_beats);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
